// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-precision adder sequencer around an external 4-bit ripple-carry adder, LS nibble first.
// Optional ADD_SUB_EN adds a 'sub' input (A-B via inverted B, carry-in 1) and an 'ovf' output.
`timescale 1ns/1ps
module nibble_serial_adder_ctrl #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   input  logic                   c_in,
`ifdef ADD_SUB_EN
   input  logic                   sub,
`endif
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   c_out,
`ifdef ADD_SUB_EN
   output logic                   ovf,
`endif
   output logic [3:0]             add_x,
   output logic [3:0]             add_y,
   output logic                   add_z,
   input  logic [3:0]             add_s,
   input  logic                   add_c
);

   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned IDXW = $clog2(NIBBLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic              cy_q, cy_d;
   logic [W-1:0]      res_d;
   logic              cout_d;
   logic              busy_d;
   logic              done_d;
   logic              sub_q;
   logic [3:0]        nib_a;
   logic [3:0]        nib_b;
   logic [3:0]        nib_y;

`ifdef ADD_SUB_EN
   logic              sub_d;
   logic              ovf_d;
`else
   assign sub_q = 1'b0;
`endif

   // Next-state, register next values and adder drive
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      cy_d    = cy_q;
      res_d   = result;
      cout_d  = c_out;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      nib_a   = 4'd0;
      nib_b   = 4'd0;
      add_x   = 4'd0;
      add_y   = 4'd0;
      add_z   = 1'b0;
`ifdef ADD_SUB_EN
      sub_d   = sub_q;
      ovf_d   = ovf;
`endif

      for (int unsigned k = 0; k < NIBBLES; k++) begin
         if (idx_q == IDXW'(k)) begin
            nib_a = a_q[4*k +: 4];
            nib_b = b_q[4*k +: 4];
         end
      end
      // Subtraction feeds the one's complement of B; the +1 comes from the initial carry
      nib_y = nib_b ^ {4{sub_q}};

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               a_d     = op_a;
               b_d     = op_b;
               idx_d   = '0;
               res_d   = '0;
               cout_d  = 1'b0;
               busy_d  = 1'b1;
`ifdef ADD_SUB_EN
               sub_d   = sub;
               cy_d    = sub ? 1'b1 : c_in;
               ovf_d   = 1'b0;
`else
               cy_d    = c_in;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            add_x = nib_a;
            add_y = nib_y;
            add_z = cy_q;
            for (int unsigned k = 0; k < NIBBLES; k++) begin
               if (idx_q == IDXW'(k)) begin
                  res_d[4*k +: 4] = add_s;
               end
            end
            cy_d  = add_c;
            idx_d = idx_q + IDXW'(1);
            if (idx_q == IDXW'(NIBBLES - 1)) begin
               state_d = DONE;
               cout_d  = add_c;
               done_d  = 1'b1;
`ifdef ADD_SUB_EN
               // Carry into the MSB is recovered from its sum bit and operand bits
               ovf_d   = (add_s[3] ^ nib_a[3] ^ nib_y[3]) ^ add_c;
`endif
            end else begin
               busy_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cy_q    <= 1'b0;
         result  <= '0;
         c_out   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cy_q    <= cy_d;
         result  <= res_d;
         c_out   <= cout_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

`ifdef ADD_SUB_EN
   // Subtract mode and overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_q <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         sub_q <= sub_d;
         ovf   <= ovf_d;
      end
   end
`endif

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with a behavioural 4-bit adder on the add_* bus.
`timescale 1ns/1ps
module tb_nibble_serial_adder_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        c_in;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        c_out;
   logic [3:0]  add_x;
   logic [3:0]  add_y;
   logic        add_z;
   logic [3:0]  add_s;
   logic        add_c;
`ifdef ADD_SUB_EN
   logic        sub;
   logic        ovf;
`endif

   int total = 0;
   int bad   = 0;
   logic [3:0] x0, y0;
   logic       z0;

   nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_a   (op_a),
      .op_b   (op_b),
      .c_in   (c_in),
`ifdef ADD_SUB_EN
      .sub    (sub),
      .ovf    (ovf),
`endif
      .busy   (busy),
      .done   (done),
      .result (result),
      .c_out  (c_out),
      .add_x  (add_x),
      .add_y  (add_y),
      .add_z  (add_z),
      .add_s  (add_s),
      .add_c  (add_c)
   );

   // The 4-bit ripple-carry adder the sequencer drives
   assign {add_c, add_s} = 5'(add_x) + 5'(add_y) + 5'(add_z);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operation: accept, check four busy cycles, done pulse, sum and idle bus
   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [15:0] exp_res, input logic exp_co);
      int cyc;
      int nbusy;
      op_a  = a;
      op_b  = b;
      c_in  = ci;
      start = 1'b1;
      tick();
      start = 1'b0;
      x0 = add_x;
      y0 = add_y;
      z0 = add_z;
      cyc   = 0;
      nbusy = 0;
      while (done !== 1'b1 && cyc < 10) begin
         if (busy === 1'b1) nbusy++;
         tick();
         cyc++;
      end
      chk({tag, " latency"}, 32'(cyc), 32'd4);
      chk({tag, " busy cycles"}, 32'(nbusy), 32'd4);
      chk({tag, " busy at done"}, 32'(busy), 32'd0);
      chk({tag, " result"}, 32'(result), 32'(exp_res));
      chk({tag, " c_out"}, 32'(c_out), 32'(exp_co));
      chk({tag, " bus idle"}, 32'({add_x, add_y, add_z}), 32'd0);
      tick();
      chk({tag, " done pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      logic [19:0] dmask;
      logic [16:0] exp17;
      logic [15:0] ra, rb;
      logic        rc;
      int          ndone;
      int          res_bad;

      rst_n = 1'b0;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      c_in  = 1'b0;
`ifdef ADD_SUB_EN
      sub   = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset result", 32'(result), 32'd0);
      chk("reset c_out", 32'(c_out), 32'd0);
      chk("reset bus", 32'({add_x, add_y, add_z}), 32'd0);
      rst_n = 1'b1;
      tick();

      // Plain add; first RUN cycle presents the LS nibbles with carry-in 0
      do_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
      chk("t1 x0", 32'(x0), 32'h4);
      chk("t1 y0", 32'(y0), 32'h1);
      chk("t1 z0", 32'(z0), 32'd0);

      // Carry ripples across every nibble
      do_op("t2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
      chk("t2 x0", 32'(x0), 32'hF);
      chk("t2 z0", 32'(z0), 32'd1);

      do_op("t2b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
      do_op("t2c", 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0);

      // start held high: done every fifth cycle, starts during RUN ignored
      op_a  = 16'h0001;
      op_b  = 16'h0002;
      c_in  = 1'b0;
      start = 1'b1;
      tick();
      dmask   = '0;
      res_bad = 0;
      for (int i = 1; i < 20; i++) begin
         tick();
         dmask[i] = done;
         if (done === 1'b1 && result !== 16'h0003) res_bad++;
      end
      start = 1'b0;
      chk("t3 done mask", 32'(dmask), 32'h84210);
      chk("t3 results", 32'(res_bad), 32'd0);
      repeat (2) tick();
      chk("t3 idle", 32'(busy), 32'd0);

      // Reset in RUN cycle 2 aborts without a done
      op_a  = 16'hABCD;
      op_b  = 16'h1111;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("t4 busy", 32'(busy), 32'd0);
      chk("t4 done", 32'(done), 32'd0);
      chk("t4 result", 32'(result), 32'd0);
      chk("t4 c_out", 32'(c_out), 32'd0);
      chk("t4 bus", 32'({add_x, add_y, add_z}), 32'd0);
      tick();
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done === 1'b1) ndone++;
      end
      chk("t4 no done", 32'(ndone), 32'd0);
      do_op("t4 after", 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0);

      // Random operands against the bench's own sum
      for (int n = 0; n < 1000; n++) begin
         ra    = 16'($urandom);
         rb    = 16'($urandom);
         rc    = 1'($urandom);
         exp17 = {1'b0, ra} + {1'b0, rb} + 17'(rc);
         do_op("t5", ra, rb, rc, exp17[15:0], exp17[16]);
      end

`ifdef ADD_SUB_EN
      sub = 1'b1;
      do_op("t6a", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
      chk("t6a ovf", 32'(ovf), 32'd0);
      do_op("t6b", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b0);
      chk("t6b ovf", 32'(ovf), 32'd1);
      sub = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
